// File: rtl/ps2_move_decoder.sv
// ps2_move_decoder: PS/2 frame receiver with arrow-key tracking that drives moveX/moveY codes
module ps2_move_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [1:0] moveX,
    output logic [1:0] moveY,
    output logic [7:0] scanCode,
    output logic       codeValid,
    output logic       frameError
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] f_last = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] t_max = TW'(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;
    logic [1:0]    clk_s, dat_s;
    logic          filt;
    logic [FW-1:0] fcnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    frame;
    logic [TW-1:0] tcnt;
    logic          strobe, timeout, last_bit, good;
    state_t        state, state_n;
    logic [3:0]    held, held_n, mask;
    function automatic logic [1:0] resolve(input logic a, input logic b);
        return (a & ~b) ? 2'd0 : (b & ~a) ? 2'd1 : 2'd2;
    endfunction
    assign strobe   = filt & ~clk_s[1] & (fcnt == f_last);
    assign timeout  = (bit_cnt != 4'd0) & (tcnt == t_max) & ~strobe;
    assign last_bit = strobe & (bit_cnt == 4'd10);
    // frame[0] is the start bit, frame[9] the parity bit; the stop bit is the live sample
    assign good     = ~frame[0] & dat_s[1] & (^frame[9:1]);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s <= 2'b11;
            dat_s <= 2'b11;
            filt  <= 1'b1;
            fcnt  <= '0;
        end else begin
            clk_s <= {clk_s[0], ps2Clk};
            dat_s <= {dat_s[0], ps2Data};
            if (clk_s[1] == filt) fcnt <= '0;
            else if (fcnt == f_last) begin
                fcnt <= '0;
                filt <= ~filt;
            end else fcnt <= fcnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= 4'd0;
            frame      <= '0;
            tcnt       <= '0;
            scanCode   <= 8'h00;
            codeValid  <= 1'b0;
            frameError <= 1'b0;
        end else begin
            codeValid  <= last_bit & good;
            frameError <= (last_bit & ~good) | timeout;
            if (last_bit & good) scanCode <= frame[8:1];
            if (timeout | last_bit) bit_cnt <= 4'd0;
            else if (strobe) begin
                frame[bit_cnt] <= dat_s[1];
                bit_cnt        <= bit_cnt + 1'b1;
            end
            tcnt <= (strobe | (bit_cnt == 4'd0)) ? '0 : (tcnt == t_max) ? tcnt : tcnt + 1'b1;
        end
    end
    assign mask = (scanCode == 8'h75) ? 4'b0001 :
                  (scanCode == 8'h72) ? 4'b0010 :
                  (scanCode == 8'h6B) ? 4'b0100 :
                  (scanCode == 8'h74) ? 4'b1000 : 4'b0000;
    always_comb begin
        state_n = state;
        held_n  = held;
        if (frameError) state_n = IDLE;
        else if (codeValid) begin
            case (state)
                IDLE: begin
                    state_n = (scanCode == 8'hE0) ? EXT : (scanCode == 8'hF0) ? BRK : IDLE;
                    held_n  = (scanCode == 8'hAA) ? 4'b0000 : held;
                end
                EXT: begin
                    state_n = (scanCode == 8'hE0) ? EXT : (scanCode == 8'hF0) ? EXTBRK : IDLE;
                    held_n  = held | mask;
                end
                BRK: state_n = IDLE;
                default: begin
                    state_n = IDLE;
                    held_n  = held & ~mask;
                end
            endcase
        end
    end
    // outputs resolve from next-state flags so they land one cycle after codeValid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            held  <= 4'b0000;
            moveX <= 2'd2;
            moveY <= 2'd2;
        end else begin
            state <= state_n;
            held  <= held_n;
            moveY <= resolve(held_n[0], held_n[1]);
            moveX <= resolve(held_n[2], held_n[3]);
        end
    end
endmodule
